player_draw: RTL
================

# player_draw

Pixel-plotting stage directly downstream of the player position datapath. Watches the player's top-left coordinate and, whenever it differs from what is currently on screen, erases the old sprite with the background colour and draws it at the new position. It emits one pixel per clock to the 160x120 VGA adapter and reports busy/done to the top-level controller.

## Interface
- SPRITE_W, 12: sprite width in pixels (1..40)
- SPRITE_H, 12: sprite height in pixels (1..20)
- PLAYER_COLOUR, 3'b010: fill colour of the sprite
- BG_COLOUR, 3'b000: erase colour
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- x_in  in  8  player top-left x from the position datapath (0..159)
- y_in  in  7  player top-left y (0..119)
- enable  in  1  when low, no new erase/draw starts; a running operation completes
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- vga_colour  out  3  pixel colour
- plot  out  1  write strobe, one pixel per high cycle
- busy  out  1  high while an erase/draw operation is in progress
- done  out  1  one-cycle pulse when an operation finishes

## Operation
- Internal registers:
  - drawn_x / drawn_y: position currently on screen.
  - drawn_valid: 0 after reset.
  - tgt_x / tgt_y: latched target position.
  - Column counter cx (0..SPRITE_W-1) and row counter cy (0..SPRITE_H-1).
- States: IDLE, ERASE, DRAW, DONE.
- IDLE: a start condition exists when enable=1 and either drawn_valid=0 or (x_in,y_in) differs from (drawn_x,drawn_y).
  - On start, latch tgt <= (x_in,y_in) and clear cx and cy.
  - Go to ERASE if drawn_valid=1; otherwise go to DRAW.
- ERASE: scans the rectangle at drawn_x/drawn_y with BG_COLOUR.
  - Row-major order: cx increments; on wrap, cy increments.
  - After pixel (SPRITE_W-1, SPRITE_H-1), clear the counters and go to DRAW.
- DRAW: scans the rectangle at tgt_x/tgt_y with PLAYER_COLOUR in the same order.
  - After the last pixel: drawn <= tgt, drawn_valid <= 1, go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Input changes while busy are ignored. x_in/y_in are re-sampled only in IDLE, so only the final position after a burst of moves is rendered.
- Pixel address: vga_x = base_x + cx and vga_y = base_y + cy.
  - Compute the sums at 9 and 8 bits.
  - If a sum is ≥160 (x) or ≥120 (y), hold plot=0 for that cycle but still advance the counters. Operation length is therefore fixed.
- Reset values: state=IDLE, drawn_valid=0, drawn=(0,0), counters=0, vga_x=0, vga_y=0, vga_colour=BG_COLOUR, plot=0, busy=0, done=0.
- Reset asserted mid-operation aborts immediately: plot drops, and a full redraw occurs after reset releases. A partly drawn sprite is left on screen; the top level clears the screen on reset.

## Timing
- All outputs are registered.
- Start decided in IDLE cycle T: plot is first high in cycle T+1.
- ERASE occupies exactly SPRITE_W*SPRITE_H cycles. DRAW follows with no gap and occupies the same number of cycles.
- done is high in the cycle after the last DRAW pixel. busy is high from T+1 through the done cycle inclusive.
- Total latency from start to done, with erase: 2·W·H+1 cycles (289 at defaults). Without erase: W·H+1 cycles.
- The earliest next start decision is the cycle after done, with plot resuming one cycle later.
- enable is sampled only in IDLE.

## Structure
- Shared package holds:
  - Screen constants: SCREEN_W=160, SCREEN_H=120.
  - Lane x positions: 14, 54, 94, 134; player row y=99.
  - Colour constants: BLACK, GREEN, etc.
  - State encoding for this FSM.
- One natural sub-module, rect_scanner: the cx/cy counter pair.
  - Inputs: start, advance.
  - Outputs: cx, cy, last (asserted on final pixel).
  - Used by both ERASE and DRAW.

## Test plan
- Reset, then enable=1 with x_in=14, y_in=99:
  - No erase phase.
  - 144 plots at x 14..25, y 99..110, colour 3'b010, in row-major order.
  - done pulses 145 cycles after start; busy low afterwards.
- From drawn (14,99), x_in→54:
  - 144 plots at x 14..25 with colour 3'b000, immediately followed by 144 plots at x 54..65 with colour 3'b010.
  - done at cycle 289.
- During the erase phase of a 54→94 move, drive x_in 94→134→94:
  - The target stays 94; no second operation starts, because x_in equals drawn after done.
- Hold x_in at 134 with enable=0 from a drawn state of 94:
  - No plot.
  - Raise enable: the operation starts the next cycle.
- Set x_in=155:
  - DRAW spans 144 cycles, but plot is asserted only for columns 155..159 (60 pixels).
- Assert reset at DRAW pixel 50:
  - plot, busy and done are 0 immediately.
  - After release: a fresh DRAW-only operation of 144 pixels.

Source files
------------

// File: rtl/player_draw_pkg.sv
// Shared constants for the player sprite renderer: screen geometry, lane
// positions, the 3-bit VGA palette and the draw FSM state encoding.
package player_draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [7:0] LANE_X0  = 8'd14;
    localparam logic [7:0] LANE_X1  = 8'd54;
    localparam logic [7:0] LANE_X2  = 8'd94;
    localparam logic [7:0] LANE_X3  = 8'd134;
    localparam logic [6:0] PLAYER_Y = 7'd99;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    // Counter widths cover the largest allowed sprite (40 x 20).
    localparam int CX_W = 6;
    localparam int CY_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/player_draw_if.sv
// Pixel write bus towards the 160x120 VGA adapter.
// plot is a one-cycle write strobe qualifying vga_x/vga_y/vga_colour; there is
// no ready and no back-pressure: every cycle with plot high writes one pixel.
interface player_draw_if;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    modport master (output vga_x, output vga_y, output vga_colour, output plot);
    modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  plot);

endinterface

// File: rtl/player_draw_rect_scanner.sv
// Row-major column/row counter pair walking a SPRITE_W x SPRITE_H rectangle.
// cx/cy present the pixel that will be current next cycle so the caller can register its address.
module player_draw_rect_scanner
    import player_draw_pkg::*;
#(
    parameter int SPRITE_W = 12,
    parameter int SPRITE_H = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            advance,
    output logic [CX_W-1:0] cx,
    output logic [CY_W-1:0] cy,
    output logic            last
);

    logic [CX_W-1:0] cx_q;
    logic [CY_W-1:0] cy_q;
    logic            col_last;

    assign col_last = (cx_q == CX_W'(SPRITE_W - 1));
    assign last     = col_last && (cy_q == CY_W'(SPRITE_H - 1));

    always_comb begin
        cx = cx_q;
        cy = cy_q;
        if (start) begin
            cx = '0;
            cy = '0;
        end else if (advance) begin
            if (col_last) begin
                cx = '0;
                cy = (cy_q == CY_W'(SPRITE_H - 1)) ? '0 : cy_q + 1'b1;
            end else begin
                cx = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx;
            cy_q <= cy;
        end
    end

endmodule

// File: rtl/player_draw.sv
// Erases the player sprite at its old position and redraws it at the new one,
// one registered pixel per clock, whenever the input position moves.
module player_draw
    import player_draw_pkg::*;
#(
    parameter int         SPRITE_W      = 12,
    parameter int         SPRITE_H      = 12,
    parameter logic [2:0] PLAYER_COLOUR = GREEN,
    parameter logic [2:0] BG_COLOUR     = BLACK
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           x_in,
    input  logic [6:0]           y_in,
    input  logic                 enable,
    output logic                 busy,
    output logic                 done,
    player_draw_if.master        vga,
    output state_t               dbg_state
);

    state_t          state, nxt_state;
    logic            drawn_valid;
    logic [7:0]      drawn_x, tgt_x, tgt_x_nxt, base_x;
    logic [6:0]      drawn_y, tgt_y, tgt_y_nxt, base_y;
    logic            start_op, scan_start, scan_adv, last;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;
    logic            scanning, in_range;

    player_draw_rect_scanner #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_scan (
        .clock   (clock),
        .reset   (reset),
        .start   (scan_start),
        .advance (scan_adv),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );

    always_comb begin
        nxt_state  = state;
        start_op   = 1'b0;
        scan_start = 1'b0;
        scan_adv   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && (!drawn_valid || x_in != drawn_x || y_in != drawn_y)) begin
                    start_op   = 1'b1;
                    scan_start = 1'b1;
                    nxt_state  = drawn_valid ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE: begin
                scan_adv   = 1'b1;
                if (last) begin
                    scan_start = 1'b1;
                    nxt_state  = S_DRAW;
                end
            end
            S_DRAW: begin
                scan_adv = 1'b1;
                if (last) nxt_state = S_DONE;
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle values so plot rises the cycle after the start decision.
    always_comb begin
        tgt_x_nxt = start_op ? x_in : tgt_x;
        tgt_y_nxt = start_op ? y_in : tgt_y;
        base_x    = (nxt_state == S_ERASE) ? drawn_x : tgt_x_nxt;
        base_y    = (nxt_state == S_ERASE) ? drawn_y : tgt_y_nxt;
        sum_x     = {1'b0, base_x} + 9'(cx);
        sum_y     = {1'b0, base_y} + 8'(cy);
        scanning  = (nxt_state == S_ERASE) || (nxt_state == S_DRAW);
        in_range  = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            drawn_valid    <= 1'b0;
            drawn_x        <= '0;
            drawn_y        <= '0;
            tgt_x          <= '0;
            tgt_y          <= '0;
            vga.vga_x      <= '0;
            vga.vga_y      <= '0;
            vga.vga_colour <= BG_COLOUR;
            vga.plot       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state <= nxt_state;
            tgt_x <= tgt_x_nxt;
            tgt_y <= tgt_y_nxt;
            if (state == S_DRAW && last) begin
                drawn_x     <= tgt_x;
                drawn_y     <= tgt_y;
                drawn_valid <= 1'b1;
            end
            if (scanning) begin
                vga.vga_x      <= sum_x[7:0];
                vga.vga_y      <= sum_y[6:0];
                vga.vga_colour <= (nxt_state == S_DRAW) ? PLAYER_COLOUR : BG_COLOUR;
            end
            vga.plot <= scanning && in_range;
            busy     <= (nxt_state != S_IDLE);
            done     <= (nxt_state == S_DONE);
        end
    end

    assign dbg_state = state;

endmodule
